// File: rtl/cajero_pkg.sv
// Shared definitions for the ATM arbiter: FSM encoding, result codes and
// the engine-response priority encoder.
package cajero_pkg;

   localparam int MONTO_W_DEF = 32;

   typedef enum logic [4:0] {
      IDLE    = 5'b00001,
      TIPO    = 5'b00010,
      MONTO_S = 5'b00100,
      ESPERA  = 5'b01000,
      FIN     = 5'b10000
   } estado_t;

   typedef enum logic [1:0] {
      RES_TIMEOUT = 2'b00,
      RES_DEP_OK  = 2'b01,
      RES_RET_OK  = 2'b10,
      RES_FONDOS  = 2'b11
   } resultado_t;

   // Insufficient funds dominates; a bare balance update is qualified by the type.
   function automatic resultado_t codificar_respuesta(input logic fondos,
                                                      input logic entregar,
                                                      input logic balance,
                                                      input logic tipo);
      if (fondos)
         return RES_FONDOS;
      else if (entregar)
         return RES_RET_OK;
      else if (balance)
         return tipo ? RES_RET_OK : RES_DEP_OK;
      else
         return RES_TIMEOUT;
   endfunction

endpackage

// File: rtl/cajero_arbitro_rr_sel.sv
// Combinational round-robin selector: first requester strictly after the
// pointer, searching upward with wrap-around.
module rr_sel #(
   parameter int NUM_TERM = 4,
   parameter int IDX_W    = 2
) (
   input  logic [NUM_TERM-1:0] req,
   input  logic [IDX_W-1:0]    puntero,
   output logic                valido,
   output logic [IDX_W-1:0]    indice
);

   always_comb begin
      int j;
      valido = 1'b0;
      indice = '0;
      j      = 0;
      // Walk from the farthest candidate down so the nearest one is written last.
      for (int k = NUM_TERM; k >= 1; k--) begin
         j = int'(puntero) + k;
         if (j >= NUM_TERM)
            j = j - NUM_TERM;
         if (req[j]) begin
            valido = 1'b1;
            indice = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/cajero_arbitro.sv
// Round-robin arbiter sharing one ATM transaction engine among NUM_TERM
// terminals; sequences the engine strobes and routes the result back.
module cajero_arbitro
   import cajero_pkg::*;
#(
   parameter int NUM_TERM = 4,
   parameter int IDX_W    = 2,
   parameter int MONTO_W  = MONTO_W_DEF,
   parameter int TIMEOUT  = 16
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic [NUM_TERM-1:0]         REQ,
   input  logic [NUM_TERM-1:0]         TIPO_REQ,
   input  logic [NUM_TERM*MONTO_W-1:0] MONTO_REQ,
   output logic [NUM_TERM-1:0]         GNT,
   output logic [NUM_TERM-1:0]         DONE,
   output logic [1:0]                  RESULTADO,
   output logic                        OCUPADO,
   output logic                        TIPO_STB,
   output logic                        TIPO_TRANS,
   output logic                        MONTO_STB,
   output logic [MONTO_W-1:0]          MONTO,
   input  logic                        BALANCE_ACTUALIZADO,
   input  logic                        ENTREGAR_DINERO,
   input  logic                        FONDOS_INSUFICIENTES
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   estado_t             estado, estado_sig;
   logic [IDX_W-1:0]    puntero, indice, sel_indice;
   logic                sel_valido;
   logic [CNT_W-1:0]    cuenta, cuenta_sig;
   logic                carga;
   logic [NUM_TERM-1:0] done_sig;
   logic [1:0]          res_sig;
   logic                hay_resp;

   rr_sel #(
      .NUM_TERM (NUM_TERM),
      .IDX_W    (IDX_W)
   ) u_rr_sel (
      .req     (REQ),
      .puntero (puntero),
      .valido  (sel_valido),
      .indice  (sel_indice)
   );

   assign hay_resp = FONDOS_INSUFICIENTES | ENTREGAR_DINERO | BALANCE_ACTUALIZADO;
   assign OCUPADO  = (estado != IDLE);
   assign GNT      = OCUPADO ? (NUM_TERM'(1) << indice) : '0;

   always_comb begin
      estado_sig = estado;
      cuenta_sig = cuenta;
      carga      = 1'b0;
      done_sig   = '0;
      res_sig    = RES_TIMEOUT;
      case (estado)
         IDLE: begin
            if (sel_valido) begin
               carga      = 1'b1;
               estado_sig = TIPO;
            end
         end
         TIPO: estado_sig = MONTO_S;
         // The engine answers combinationally to MONTO_STB, so look here too.
         MONTO_S: begin
            if (hay_resp) begin
               estado_sig = FIN;
               done_sig   = NUM_TERM'(1) << indice;
               res_sig    = codificar_respuesta(FONDOS_INSUFICIENTES, ENTREGAR_DINERO,
                                                BALANCE_ACTUALIZADO, TIPO_TRANS);
            end else begin
               estado_sig = ESPERA;
            end
         end
         ESPERA: begin
            if (hay_resp) begin
               estado_sig = FIN;
               cuenta_sig = '0;
               done_sig   = NUM_TERM'(1) << indice;
               res_sig    = codificar_respuesta(FONDOS_INSUFICIENTES, ENTREGAR_DINERO,
                                                BALANCE_ACTUALIZADO, TIPO_TRANS);
            end else if (cuenta == CNT_W'(TIMEOUT - 1)) begin
               estado_sig = FIN;
               cuenta_sig = '0;
               done_sig   = NUM_TERM'(1) << indice;
               res_sig    = RES_TIMEOUT;
            end else begin
               cuenta_sig = cuenta + CNT_W'(1);
            end
         end
         FIN:     estado_sig = IDLE;
         default: estado_sig = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         estado     <= IDLE;
         puntero    <= IDX_W'(NUM_TERM - 1);
         indice     <= '0;
         cuenta     <= '0;
         TIPO_STB   <= 1'b0;
         MONTO_STB  <= 1'b0;
         DONE       <= '0;
         RESULTADO  <= '0;
         TIPO_TRANS <= 1'b0;
         MONTO      <= '0;
      end else begin
         estado    <= estado_sig;
         cuenta    <= cuenta_sig;
         TIPO_STB  <= (estado_sig == TIPO);
         MONTO_STB <= (estado_sig == MONTO_S);
         DONE      <= done_sig;
         RESULTADO <= res_sig;
         if (carga) begin
            indice     <= sel_indice;
            puntero    <= sel_indice;
            TIPO_TRANS <= TIPO_REQ[sel_indice];
            MONTO      <= MONTO_REQ[sel_indice*MONTO_W +: MONTO_W];
         end
      end
   end

endmodule

// File: tb/tb_cajero_arbitro.sv
// Self-checking bench for cajero_arbitro: scoreboard of expected completions,
// a table of single transactions and directed multi-cycle sequences.
module tb_cajero_arbitro;
   import cajero_pkg::*;

   localparam int NT = 4;
   localparam int IW = 2;
   localparam int MW = 32;
   localparam int TO = 16;

   logic              Clk = 1'b0;
   logic              Reset = 1'b1;
   logic [NT-1:0]     REQ = '0;
   logic [NT-1:0]     TIPO_REQ = '0;
   logic [NT*MW-1:0]  MONTO_REQ = '0;
   logic [NT-1:0]     GNT, DONE;
   logic [1:0]        RESULTADO;
   logic              OCUPADO, TIPO_STB, TIPO_TRANS, MONTO_STB;
   logic [MW-1:0]     MONTO;
   logic              BALANCE_ACTUALIZADO, ENTREGAR_DINERO, FONDOS_INSUFICIENTES;

   cajero_arbitro #(.NUM_TERM(NT), .IDX_W(IW), .MONTO_W(MW), .TIMEOUT(TO)) dut (
      .Clk                  (Clk),
      .Reset                (Reset),
      .REQ                  (REQ),
      .TIPO_REQ             (TIPO_REQ),
      .MONTO_REQ            (MONTO_REQ),
      .GNT                  (GNT),
      .DONE                 (DONE),
      .RESULTADO            (RESULTADO),
      .OCUPADO              (OCUPADO),
      .TIPO_STB             (TIPO_STB),
      .TIPO_TRANS           (TIPO_TRANS),
      .MONTO_STB            (MONTO_STB),
      .MONTO                (MONTO),
      .BALANCE_ACTUALIZADO  (BALANCE_ACTUALIZADO),
      .ENTREGAR_DINERO      (ENTREGAR_DINERO),
      .FONDOS_INSUFICIENTES (FONDOS_INSUFICIENTES)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Engine model: responds eng_delay cycles after MONTO_STB (0 = same cycle,
   // negative = never); eng_force injects responses at arbitrary times.
   logic [2:0] eng_resp = 3'b000;
   logic [2:0] eng_force = 3'b000;
   int         eng_delay = -1;
   int         cyc = 0;
   logic       fire;

   always @(posedge Clk) begin
      if (Reset)
         cyc <= 0;
      else if (MONTO_STB)
         cyc <= 1;
      else if (cyc != 0 && cyc < 1000)
         cyc <= cyc + 1;
   end

   always_comb begin
      fire = 1'b0;
      if (eng_delay == 0)
         fire = MONTO_STB;
      else if (eng_delay > 0)
         fire = (cyc == eng_delay);
      {FONDOS_INSUFICIENTES, ENTREGAR_DINERO, BALANCE_ACTUALIZADO} =
         (fire ? eng_resp : 3'b000) | eng_force;
   end

   typedef struct {
      int         term;
      logic [1:0] res;
      logic [31:0] monto;
      logic       tipo;
   } exp_t;

   exp_t sb[$];

   always @(negedge Clk) begin
      exp_t e;
      if (MONTO_STB && sb.size() > 0) begin
         chk("monto_out", MONTO, sb[0].monto);
         chk("tipo_trans", 32'(TIPO_TRANS), 32'(sb[0].tipo));
         chk("gnt_at_monto", 32'(GNT), 32'(1) << sb[0].term);
      end
      if (DONE != '0) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(DONE), 0);
         end else begin
            e = sb.pop_front();
            chk("done", 32'(DONE), 32'(1) << e.term);
            chk("resultado", 32'(RESULTADO), 32'(e.res));
         end
      end
   end

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge Clk);
         n++;
      end while (DONE == '0 && n < 60);
      if (DONE == '0) begin
         chk("done_timeout", 32'(DONE), 1);
         sb.delete();
      end
   endtask

   task automatic set_montos(input int term, input logic [31:0] m);
      for (int i = 0; i < NT; i++)
         MONTO_REQ[i*MW +: MW] = (i == term) ? m : ~m;
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  tipo;
      logic [31:0] monto;
      int          delay;
      logic [2:0]  resp;   // {fondos, entregar, balance}
      int          term;
      logic [1:0]  res;
      int          lat;
   } vec_t;

   vec_t tabla[7];

   initial begin
      int n;
      exp_t e;

      tabla[0] = '{4'b0100, 4'b0100, 32'd500,        3, 3'b101, 2, 2'b11, 6};
      tabla[1] = '{4'b1010, 4'b1010, 32'd77,         0, 3'b001, 3, 2'b10, 3};
      tabla[2] = '{4'b1010, 4'b1010, 32'd88,         1, 3'b010, 1, 2'b10, 4};
      tabla[3] = '{4'b0011, 4'b0010, 32'd0,          0, 3'b001, 0, 2'b01, 3};
      tabla[4] = '{4'b1001, 4'b0000, 32'hFFFF_FFFF,  2, 3'b011, 3, 2'b10, 5};
      tabla[5] = '{4'b0001, 4'b0001, 32'd5,          0, 3'b100, 0, 2'b11, 3};
      tabla[6] = '{4'b0010, 4'b0000, 32'd321,       -1, 3'b000, 1, 2'b00, 19};

      // Reset state
      repeat (3) @(negedge Clk);
      chk("rst_gnt", 32'(GNT), 0);
      chk("rst_done", 32'(DONE), 0);
      chk("rst_ocupado", 32'(OCUPADO), 0);
      chk("rst_tipo_stb", 32'(TIPO_STB), 0);
      chk("rst_monto_stb", 32'(MONTO_STB), 0);
      chk("rst_monto", MONTO, 0);
      chk("rst_resultado", 32'(RESULTADO), 0);
      chk("rst_tipo_trans", 32'(TIPO_TRANS), 0);
      Reset = 1'b0;
      @(negedge Clk);

      // Single deposit with immediate response: strobe timing
      REQ = 4'b0001; TIPO_REQ = 4'b0000; set_montos(0, 32'd100);
      eng_resp = 3'b001; eng_delay = 0;
      e = '{0, 2'b01, 32'd100, 1'b0}; sb.push_back(e);
      @(negedge Clk);
      chk("t1_tipo_stb", 32'(TIPO_STB), 1);
      chk("t1_monto_stb_early", 32'(MONTO_STB), 0);
      chk("t1_gnt", 32'(GNT), 32'h1);
      chk("t1_ocupado", 32'(OCUPADO), 1);
      @(negedge Clk);
      chk("t1_monto_stb", 32'(MONTO_STB), 1);
      chk("t1_tipo_stb_low", 32'(TIPO_STB), 0);
      @(negedge Clk);
      chk("t1_done", 32'(DONE), 32'h1);
      chk("t1_gnt_fin", 32'(GNT), 32'h1);
      REQ = 4'b0000;
      @(negedge Clk);
      chk("t1_idle_ocupado", 32'(OCUPADO), 0);
      chk("t1_idle_done", 32'(DONE), 0);

      // All four requesting continuously: 0,1,2,3,0 every 4 cycles
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      TIPO_REQ = 4'b1010;
      for (int i = 0; i < NT; i++) MONTO_REQ[i*MW +: MW] = 32'((i + 1) * 10);
      REQ = 4'b1111; eng_resp = 3'b001; eng_delay = 0;
      for (int k = 0; k < 5; k++) begin
         e = '{k % 4, (k % 2 == 1) ? 2'b10 : 2'b01, 32'(((k % 4) + 1) * 10), 1'(k % 2)};
         sb.push_back(e);
      end
      for (int k = 0; k < 5; k++) begin
         wait_done(n);
         chk("rr_latency", 32'(n), (k == 0) ? 32'd3 : 32'd4);
      end
      REQ = 4'b0000;
      @(negedge Clk);

      // Table of independent transactions (pointer carries over)
      for (int v = 0; v < 7; v++) begin
         TIPO_REQ = tabla[v].tipo;
         set_montos(tabla[v].term, tabla[v].monto);
         eng_resp = tabla[v].resp;
         eng_delay = tabla[v].delay;
         REQ = tabla[v].req;
         e = '{tabla[v].term, tabla[v].res, tabla[v].monto, tabla[v].tipo[tabla[v].term]};
         sb.push_back(e);
         wait_done(n);
         chk("vec_latency", 32'(n), 32'(tabla[v].lat));
         REQ = 4'b0000;
         eng_delay = -1;
         @(negedge Clk);
      end

      // Reset while waiting on a silent engine
      REQ = 4'b0001; TIPO_REQ = 4'b0000; set_montos(0, 32'd9); eng_delay = -1;
      repeat (3) @(negedge Clk);
      chk("t5_busy", 32'(OCUPADO), 1);
      Reset = 1'b1; REQ = 4'b0000;
      @(negedge Clk);
      chk("t5_gnt", 32'(GNT), 0);
      chk("t5_done", 32'(DONE), 0);
      chk("t5_ocupado", 32'(OCUPADO), 0);
      chk("t5_monto", MONTO, 0);
      chk("t5_monto_stb", 32'(MONTO_STB), 0);
      Reset = 1'b0;
      REQ = 4'b1010; TIPO_REQ = 4'b0000; set_montos(1, 32'd42);
      eng_resp = 3'b001; eng_delay = 0;
      e = '{1, 2'b01, 32'd42, 1'b0}; sb.push_back(e);
      @(negedge Clk);
      chk("t5_first_gnt", 32'(GNT), 32'h2);
      wait_done(n);
      chk("t5_latency", 32'(n), 2);
      REQ = 4'b0000;
      @(negedge Clk);

      // Engine responses while idle are ignored
      eng_delay = -1; eng_force = 3'b111;
      repeat (3) begin
         @(negedge Clk);
         chk("idle_resp_ocupado", 32'(OCUPADO), 0);
         chk("idle_resp_done", 32'(DONE), 0);
      end

      // Requester drops REQ and changes inputs after the latch
      REQ = 4'b0100; TIPO_REQ = 4'b0100; set_montos(2, 32'd1234);
      eng_resp = 3'b001; eng_delay = 2;
      e = '{2, 2'b10, 32'd1234, 1'b1}; sb.push_back(e);
      @(negedge Clk);
      eng_force = 3'b000;
      REQ = 4'b0000; TIPO_REQ = 4'b0000;
      for (int i = 0; i < NT; i++) MONTO_REQ[i*MW +: MW] = 32'd999;
      wait_done(n);
      chk("t6_latency", 32'(n), 4);
      chk("t6_monto_hold", MONTO, 32'd1234);
      eng_force = 3'b100;
      @(negedge Clk);
      chk("fin_resp_done", 32'(DONE), 0);
      chk("fin_resp_ocupado", 32'(OCUPADO), 0);
      eng_force = 3'b000;
      repeat (2) @(negedge Clk);

      chk("sb_empty", 32'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
